blake2_pmod_host: RTL and testbench

- Host-side driver for the BLAKE2 emulator's PMOD link. Sits on the tester FPGA and replaces the RPI PIO driver.
- Takes a local byte stream (valid/ready) and serialises it onto the PMOD data bus with data_ctrl framing, in blocks gated by device ready.
- Synchronises the returned hash_ctrl/hash bus and re-emits the digest on a local byte stream.
- Shares the 40 MHz bus clock with the emulator; all PMOD inputs are treated as asynchronous.

---
 rtl/blake2_pmod_host.sv | 146 ++++++++++++++
 tb/tb_blake2_pmod_host.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2_pmod_host.sv
// blake2_pmod_host: tester-side PMOD driver that frames message bytes onto the data bus and re-emits the returned digest.
// Define BLAKE2_HOST_STATS_EN to add saturating msg_cnt_o/err_cnt_o counters.
module blake2_pmod_host #(
    parameter int PMOD_W      = 8,
    parameter int BLOCK_BYTES = 64,
    parameter int HASH_BYTES  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int GUARD_CYC   = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_async,
    input  logic              msg_valid_i,
    output logic              msg_ready_o,
    input  logic [7:0]        msg_data_i,
    input  logic              msg_last_i,
    output logic              hash_valid_o,
    output logic [7:0]        hash_data_o,
    output logic              hash_last_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [PMOD_W-1:0] data_o,
    output logic [2:0]        data_ctrl_o,
    output logic [1:0]        loopback_ctrl_o,
    input  logic [PMOD_W-1:0] hash_i,
    input  logic [1:0]        hash_ctrl_i
`ifdef BLAKE2_HOST_STATS_EN
    ,
    output logic [15:0]       msg_cnt_o,
    output logic [15:0]       err_cnt_o
`endif
);
    localparam int BW = $clog2(BLOCK_BYTES + 1);
    localparam int HW = $clog2(HASH_BYTES + 1);
    localparam int GW = $clog2(GUARD_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, WAIT_RDY, SEND, GUARD, WAIT_HASH, RECV} state_t;

    state_t            state;
    logic [PMOD_W+1:0] sync_q [SYNC_STAGES];
    logic [PMOD_W-1:0] hash_s;
    logic              hv_s, rdy_s, start_pending, accept, tmo_hit, err_evt;
    logic [BW-1:0]     blk_cnt;
    logic [HW-1:0]     hash_cnt;
    logic [GW-1:0]     guard_cnt;
    logic [TW-1:0]     tmo_cnt;

    assign {hv_s, rdy_s, hash_s} = sync_q[SYNC_STAGES-1];
    assign msg_ready_o     = state == SEND;
    assign busy_o          = state != IDLE;
    assign loopback_ctrl_o = 2'b00;
    assign accept          = msg_ready_o && msg_valid_i;
    assign tmo_hit         = tmo_cnt == TW'(TIMEOUT_CYC - 1);
    // A digest strobe is only legal while a digest is expected; anywhere else it flags a device fault.
    assign err_evt = (hv_s && (state == IDLE || state == WAIT_RDY || state == SEND || state == GUARD)) ||
                     (state == WAIT_RDY && !rdy_s && tmo_hit) ||
                     (state == WAIT_HASH && !hv_s && tmo_hit) ||
                     (state == RECV && !hv_s);

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {hash_ctrl_i, hash_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state         <= IDLE;
            start_pending <= 1'b0;
            blk_cnt       <= '0;
            hash_cnt      <= '0;
            guard_cnt     <= '0;
            tmo_cnt       <= '0;
            data_o        <= '0;
            data_ctrl_o   <= 3'b000;
            hash_valid_o  <= 1'b0;
            hash_data_o   <= 8'h00;
            hash_last_o   <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            data_ctrl_o  <= accept ? {msg_last_i, start_pending, 1'b1} : 3'b000;
            hash_valid_o <= 1'b0;
            hash_last_o  <= 1'b0;
            tmo_cnt      <= '0;
            if (accept) data_o <= PMOD_W'(msg_data_i);
            if (err_evt) err_o <= 1'b1;
            case (state)
                IDLE: if (msg_valid_i) begin
                    state         <= WAIT_RDY;
                    start_pending <= 1'b1;
                end
                WAIT_RDY: if (rdy_s) begin
                    state   <= SEND;
                    blk_cnt <= '0;
                end else if (tmo_hit) state <= IDLE;
                else tmo_cnt <= tmo_cnt + 1'b1;
                SEND: if (accept) begin
                    start_pending <= 1'b0;
                    blk_cnt       <= blk_cnt + 1'b1;
                    if (msg_last_i) begin
                        state    <= WAIT_HASH;
                        hash_cnt <= '0;
                    end else if (blk_cnt == BW'(BLOCK_BYTES - 1)) begin
                        state     <= GUARD;
                        guard_cnt <= '0;
                    end
                end
                GUARD: if (guard_cnt == GW'(GUARD_CYC - 1)) state <= WAIT_RDY;
                else guard_cnt <= guard_cnt + 1'b1;
                WAIT_HASH: if (hv_s) begin
                    state        <= RECV;
                    hash_valid_o <= 1'b1;
                    hash_data_o  <= 8'(hash_s);
                    hash_cnt     <= HW'(1);
                end else if (tmo_hit) state <= IDLE;
                else tmo_cnt <= tmo_cnt + 1'b1;
                RECV: if (hv_s) begin
                    hash_valid_o <= 1'b1;
                    hash_data_o  <= 8'(hash_s);
                    hash_cnt     <= hash_cnt + 1'b1;
                    if (hash_cnt == HW'(HASH_BYTES - 1)) begin
                        hash_last_o <= 1'b1;
                        state       <= IDLE;
                    end
                end else state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BLAKE2_HOST_STATS_EN
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            msg_cnt_o <= '0;
            err_cnt_o <= '0;
        end else begin
            if (hash_last_o && msg_cnt_o != 16'hFFFF) msg_cnt_o <= msg_cnt_o + 1'b1;
            if (err_evt && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_blake2_pmod_host.sv
// tb_blake2_pmod_host: directed scenarios with random payloads, checked against a queue-based model of the link.
`timescale 1ns/1ps
module tb_blake2_pmod_host;
    localparam int SYNC = 2, GUARD = 8, TMO = 100, HB = 32, BB = 64;

    logic       clk = 1'b0, rst_async = 1'b1;
    logic       msg_valid_i = 1'b0, msg_last_i = 1'b0;
    logic [7:0] msg_data_i = 8'h00, hash_i = 8'h00;
    logic       hv_r = 1'b0, rdy_r = 1'b0;
    logic [1:0] hash_ctrl_i;
    logic       msg_ready_o, hash_valid_o, hash_last_o, busy_o, err_o;
    logic [7:0] hash_data_o, data_o;
    logic [2:0] data_ctrl_o;
    logic [1:0] loopback_ctrl_o;
`ifdef BLAKE2_HOST_STATS_EN
    logic [15:0] msg_cnt_o, err_cnt_o;
`endif

    assign hash_ctrl_i = {hv_r, rdy_r};
    always #5 clk = ~clk;

    blake2_pmod_host #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_async(rst_async),
        .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o), .msg_data_i(msg_data_i), .msg_last_i(msg_last_i),
        .hash_valid_o(hash_valid_o), .hash_data_o(hash_data_o), .hash_last_o(hash_last_o),
        .busy_o(busy_o), .err_o(err_o), .data_o(data_o), .data_ctrl_o(data_ctrl_o),
        .loopback_ctrl_o(loopback_ctrl_o), .hash_i(hash_i), .hash_ctrl_i(hash_ctrl_i)
`ifdef BLAKE2_HOST_STATS_EN
        , .msg_cnt_o(msg_cnt_o), .err_cnt_o(err_cnt_o)
`endif
    );

    typedef struct packed {logic [7:0] d; logic s; logic l; logic [31:0] cyc;} rx_t;
    rx_t        rx[$];
    logic [8:0] hrx[$];
    logic [7:0] msg[$], hq[$];
    int cyc = 0, rdy_hi = 0, err_cyc = -1;
    int n_tests = 0, n_fail = 0, good_msgs = 0, err_events = 0;
    bit abort = 1'b0;

    always @(posedge clk) cyc++;

    // Observed PMOD frames and digest strobes, time-stamped in clock cycles.
    always @(negedge clk) begin
        if (data_ctrl_o[0]) rx.push_back('{data_o, data_ctrl_o[1], data_ctrl_o[2], cyc});
        if (hash_valid_o) hrx.push_back({hash_last_o, hash_data_o});
        if (msg_ready_o) rdy_hi++;
        if (err_o && err_cyc < 0) err_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_msg(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    task automatic new_hash();
        hq.delete();
        for (int i = 0; i < HB; i++) hq.push_back(8'($urandom));
    endtask

    task automatic send_msg(input int n);
        int w;
        bit stalled = 1'b0;
        for (int i = 0; i < n && !abort && !stalled; i++) begin
            msg_valid_i = 1'b1;
            msg_data_i  = msg[i];
            msg_last_i  = (i == n - 1);
            w = 0;
            while (!msg_ready_o && !abort && w < 3000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 3000) stalled = 1'b1;
            else if (!abort) @(negedge clk);
        end
        msg_valid_i = 1'b0;
        msg_last_i  = 1'b0;
        chk("send_stall", 32'(stalled), 0);
    endtask

    task automatic give_hash(input int n);
        for (int i = 0; i < n; i++) begin
            hv_r   = 1'b1;
            hash_i = hq[i];
            @(negedge clk);
        end
        hv_r   = 1'b0;
        hash_i = 8'h00;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    task automatic check_rx(input int n);
        chk("rx_count", rx.size(), n);
        for (int i = 0; i < n && i < rx.size(); i++) begin
            chk($sformatf("rx_data[%0d]", i), rx[i].d, msg[i]);
            chk($sformatf("rx_start[%0d]", i), rx[i].s, i == 0);
            chk($sformatf("rx_last[%0d]", i), rx[i].l, i == n - 1);
        end
    endtask

    task automatic check_hash(input int n, input bit full);
        chk("hash_count", hrx.size(), n);
        for (int i = 0; i < n && i < hrx.size(); i++) begin
            chk($sformatf("hash_data[%0d]", i), hrx[i][7:0], hq[i]);
            chk($sformatf("hash_last[%0d]", i), hrx[i][8], full && i == n - 1);
        end
    endtask

    task automatic good_digest();
        hrx.delete();
        give_hash(HB);
        check_hash(HB, 1'b1);
        chk("digest_busy", busy_o, 0);
        chk("digest_err", err_o, 0);
        good_msgs++;
    endtask

    initial begin
        int w, k, snap, gap;
        repeat (3) @(negedge clk);
        chk("rst_data", data_o, 0);
        chk("rst_ctrl", data_ctrl_o, 0);
        chk("rst_ready", msg_ready_o, 0);
        chk("rst_hvalid", hash_valid_o, 0);
        chk("rst_hdata", hash_data_o, 0);
        chk("rst_hlast", hash_last_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("loopback", loopback_ctrl_o, 0);
        rst_async = 1'b0;
        rdy_r = 1'b1;
        @(negedge clk);

        // single byte message, digest 0x00..0x1F
        rx.delete();
        msg.delete();
        msg.push_back(8'hAB);
        send_msg(1);
        chk("t1_ctrl", data_ctrl_o, 3'b111);
        chk("t1_data", data_o, 8'hAB);
        @(negedge clk);
        chk("t1_ctrl_idle", data_ctrl_o, 3'b000);
        chk("t1_data_hold", data_o, 8'hAB);
        hq.delete();
        for (int i = 0; i < HB; i++) hq.push_back(8'(i));
        good_digest();

        // 130 byte message across three blocks, ready held high
        rx.delete();
        new_msg(130);
        send_msg(130);
        repeat (2) @(negedge clk);
        check_rx(130);
        for (int i = 1; i < 130 && i < rx.size(); i++) begin
            gap = int'(rx[i].cyc) - int'(rx[i-1].cyc) - 1;
            if (i % BB == 0) chk($sformatf("t2_guard_gap[%0d]", i), 32'(gap >= GUARD && gap <= GUARD + 2), 1);
            else chk($sformatf("t2_gap[%0d]", i), gap, 0);
        end
        new_hash();
        good_digest();

        // ready withdrawn for 100 cycles after the first block
        rx.delete();
        new_msg(100);
        fork
            send_msg(100);
            begin
                w = 0;
                while (rx.size() < BB && w < 3000) begin
                    @(negedge clk);
                    w++;
                end
                chk("t3_first_block", rx.size(), BB);
                rdy_r = 1'b0;
                snap = rdy_hi;
                repeat (100) @(negedge clk);
                chk("t3_ready_low", rdy_hi - snap, 0);
                chk("t3_held", rx.size(), BB);
                rdy_r = 1'b1;
                k = 0;
                while (!msg_ready_o && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                chk("t3_resume_latency", k, SYNC + 1);
            end
        join
        repeat (2) @(negedge clk);
        check_rx(100);
        new_hash();
        good_digest();

        // digest never arrives
        rx.delete();
        err_cyc = -1;
        new_msg(1);
        send_msg(1);
        w = 0;
        while (!err_o && w < TMO + 50) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("t4_err", err_o, 1);
        chk("t4_sent", rx.size(), 1);
        if (rx.size() > 0) chk("t4_timeout_cycles", err_cyc - int'(rx[0].cyc), TMO);
        chk("t4_busy", busy_o, 0);
        err_events++;
`ifdef BLAKE2_HOST_STATS_EN
        chk("stats_msg", msg_cnt_o, good_msgs);
        chk("stats_err", err_cnt_o, err_events);
`endif
        rst_async = 1'b1;
        @(negedge clk);
        rst_async = 1'b0;
        good_msgs = 0;
        err_events = 0;
        chk("t4_err_cleared", err_o, 0);

        // digest valid dropped after 20 bytes
        new_msg(1);
        send_msg(1);
        new_hash();
        hrx.delete();
        give_hash(20);
        check_hash(20, 1'b0);
        chk("t5_err", err_o, 1);
        chk("t5_busy", busy_o, 0);
        rst_async = 1'b1;
        @(negedge clk);
        rst_async = 1'b0;
        @(negedge clk);

        // reset pulse in the middle of a block
        rx.delete();
        new_msg(40);
        fork
            send_msg(40);
            begin
                w = 0;
                while (rx.size() < 10 && w < 3000) begin
                    @(negedge clk);
                    w++;
                end
                #2 rst_async = 1'b1;
                abort = 1'b1;
                #1;
                chk("t6_data", data_o, 0);
                chk("t6_ctrl", data_ctrl_o, 0);
                chk("t6_ready", msg_ready_o, 0);
                chk("t6_busy", busy_o, 0);
                chk("t6_err", err_o, 0);
                chk("t6_hvalid", hash_valid_o, 0);
                repeat (2) @(negedge clk);
                rst_async = 1'b0;
            end
        join
        abort = 1'b0;
        @(negedge clk);
        rx.delete();
        new_msg(3);
        send_msg(3);
        repeat (2) @(negedge clk);
        check_rx(3);
        new_hash();
        good_digest();
`ifdef BLAKE2_HOST_STATS_EN
        chk("stats_msg_after_rst", msg_cnt_o, good_msgs);
        chk("stats_err_after_rst", err_cnt_o, err_events);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion, expected finish within 2 ms");
        $fatal(1, "watchdog expired");
    end
endmodule
